serial_diff_controller: RTL and testbench
=========================================

// Module: serial_diff_controller
// PURPOSE
//  Bit-serial subtraction sequencer that time-shares ONE full-difference cell.
//  Sub-cells: half difference = XOR + (~a & b); full difference = two halves + OR.
//  Computes diff = a - b (two's complement, WIDTH bits), LSB first, one bit per clock.
//  The borrow is kept in a flip-flop between bits.
//  Sits in front of the arithmetic datapath as the area-cheap alternative to the
//  ripple subtractor, with a start/done handshake toward the requesting unit.
// PARAMETERS
//  WIDTH   4   operand/result width in bits (>=2); also the number of RUN cycles
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      asynchronous, active-low reset
//  start       in   1      request; sampled only when ready=1
//  abort       in   1      cancel the operation in progress (RUN only)
//  a           in   WIDTH  minuend, captured on an accepted start
//  b           in   WIDTH  subtrahend, captured on an accepted start
//  ready       out  1      1 in IDLE only (combinational from state)
//  busy        out  1      1 in RUN only
//  done        out  1      one-cycle pulse: result registers just updated
//  diff        out  WIDTH  last completed a - b mod 2^WIDTH; holds until next done
//  borrow_out  out  1      final borrow of the last completed op (1 => a < b unsigned)
//  zero        out  1      1 when the last completed diff == 0
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, ready=1, busy=0, done=0, diff=0,
//   borrow_out=0, zero=0, shift regs/count/borrow=0. Reset dominates all inputs at any time.
//  FSM states: IDLE, RUN, DONE.
//  IDLE:
//   - start=1 at edge E0: sa<=a, sb<=b, v<=0, cnt<=0, -> RUN.
//   - start=0: stay in IDLE.
//  RUN (edges E1..E_WIDTH), bit i processed at E(i+1):
//   - d_i  = sa[0] ^ sb[0] ^ v.
//   - v   <= (~sa[0] & sb[0]) | (~(sa[0]^sb[0]) & v).
//   - sr  <= {d_i, sr[WIDTH-1:1]}; sa, sb shift right by 1; cnt <= cnt+1.
//   - At the edge where cnt==WIDTH-1: diff<={d_i,sr[WIDTH-1:1]}, borrow_out<=next v,
//     zero<=(that value==0), -> DONE.
//  DONE: done=1 for exactly one cycle, -> IDLE at next edge (start is not accepted in DONE).
//  Latency: start accepted at E0 -> done high in the cycle after E_WIDTH;
//   throughput 1 op per WIDTH+2 clocks with start held high.
//  Busy handling:
//   - start while busy/DONE: ignored, no queuing; a, b only need to be stable at E0.
//   - abort=1 in RUN: -> IDLE next edge; no done; diff/borrow_out/zero keep old values.
//   - abort outside RUN: no effect.
//   - abort and cnt==WIDTH-1 on the same edge: abort wins, no result update.
//  Arithmetic: pure modulo-2^WIDTH; no saturation; diff matches a parallel WIDTH-bit
//   ripple subtractor (borrow-in 0) bit for bit, including borrow_out.
//  Outputs diff/borrow_out/zero are registered; change only on the DONE-entry edge or reset.
// TESTING
//  1. W=4, a=1001 b=0100, start 1 clk -> done after 4 clks, diff=0101, borrow_out=0, zero=0.
//  2. a=1111 b=1110 -> diff=0001, borrow_out=0; a=0111 b=1111 -> diff=1000, borrow_out=1.
//  3. a=0101 b=0101 -> diff=0000, zero=1, borrow_out=0.
//     Then a=0000 b=0001 -> diff=1111, borrow_out=1, zero=0.
//  4. Abort and start pulses during RUN:
//     - Op 9-4, start re-pulsed with a=0 b=1 during RUN -> ignored, result 0101.
//     - Next op: abort at 2nd RUN cycle -> no done, diff stays 0101, ready=1 next clk.
//  5. rst_n low mid-RUN (between edges) -> ready=1, busy=0, done=0, diff=0 immediately.
//     After release, a fresh 3-1 gives diff=0010.
//  6. WIDTH=8, start held high: 200-55 -> 145, then 55-200 -> 111 with borrow_out=1.
//     done pulses are WIDTH+2 clks apart. Random sweep vs a-b reference model, 1000 ops.

Source files
------------

// File: rtl/serial_diff_controller.sv
// Bit-serial a - b sequencer built around a single full-difference cell.
// Consumes one operand bit per clock, LSB first, keeping the borrow in a flop.

module sd_half_diff (
  input  logic i_x,
  input  logic i_y,
  output logic o_d,
  output logic o_bo
);
  assign o_d  = i_x ^ i_y;
  assign o_bo = ~i_x & i_y;
endmodule

module sd_full_diff (
  input  logic i_x,
  input  logic i_y,
  input  logic i_bi,
  output logic o_d,
  output logic o_bo
);
  logic w_d1, w_b1, w_b2;

  sd_half_diff u_h1 (.i_x(i_x),  .i_y(i_y),  .o_d(w_d1), .o_bo(w_b1));
  sd_half_diff u_h2 (.i_x(w_d1), .i_y(i_bi), .o_d(o_d),  .o_bo(w_b2));

  assign o_bo = w_b1 | w_b2;
endmodule

// state  | meaning
// S_IDLE | waiting for start, ready=1
// S_RUN  | one bit per clock through the shared cell, busy=1
// S_DONE | result registers just updated, done=1 for one cycle
module serial_diff_controller #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow_out,
  output logic             o_zero
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state, w_next;

  logic [WIDTH-1:0] r_sa, r_sb, r_sr, r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_v, r_borrow_out, r_zero;

  logic             w_d, w_v_next;
  logic             w_accept, w_step, w_last;
  logic [WIDTH-1:0] w_result;

  sd_full_diff u_cell (
    .i_x (r_sa[0]),
    .i_y (r_sb[0]),
    .i_bi(r_v),
    .o_d (w_d),
    .o_bo(w_v_next)
  );

  assign w_accept = (r_state == S_IDLE) & i_start;
  // abort takes priority over the final bit, so a cancelled op never commits
  assign w_step   = (r_state == S_RUN) & ~i_abort;
  assign w_last   = w_step & (r_cnt == LAST);
  assign w_result = {w_d, r_sr[WIDTH-1:1]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_next = S_RUN;
      S_RUN: begin
        if (i_abort)             w_next = S_IDLE;
        else if (r_cnt == LAST)  w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_ready = 1'b0;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    case (r_state)
      S_IDLE:  o_ready = 1'b1;
      S_RUN:   o_busy  = 1'b1;
      S_DONE:  o_done  = 1'b1;
      default: o_ready = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sa  <= '0;
      r_sb  <= '0;
      r_sr  <= '0;
      r_v   <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_sa  <= i_a;
      r_sb  <= i_b;
      r_v   <= 1'b0;
      r_cnt <= '0;
    end else if (w_step) begin
      r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
      r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
      r_sr  <= w_result;
      r_v   <= w_v_next;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
      r_zero       <= 1'b0;
    end else if (w_last) begin
      r_diff       <= w_result;
      r_borrow_out <= w_v_next;
      r_zero       <= (w_result == '0);
    end
  end

  assign o_diff       = r_diff;
  assign o_borrow_out = r_borrow_out;
  assign o_zero       = r_zero;

endmodule

// File: tb/tb_serial_diff_controller.sv
// Directed and random checks of serial_diff_controller at WIDTH=4 and WIDTH=8
// against a plain-arithmetic a - b reference.

module tb_serial_diff_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       s4 = 1'b0, ab4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       r4, bz4, dn4, bo4, z4;
  logic [3:0] df4;

  logic       s8 = 1'b0, ab8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       r8, bz8, dn8, bo8, z8;
  logic [7:0] df8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_diff_controller #(.WIDTH(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(s4), .i_abort(ab4), .i_a(a4), .i_b(b4),
    .o_ready(r4), .o_busy(bz4), .o_done(dn4), .o_diff(df4), .o_borrow_out(bo4), .o_zero(z4)
  );

  serial_diff_controller #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(s8), .i_abort(ab8), .i_a(a8), .i_b(b8),
    .o_ready(r8), .o_busy(bz8), .o_done(dn8), .o_diff(df8), .o_borrow_out(bo8), .o_zero(z8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one WIDTH=4 operation with start pulsed for one clock; result judged by integer a - b
  task automatic op4(input int a, input int b);
    int n;
    int ed;
    ed = (a - b + 16) % 16;
    a4 = 4'(a); b4 = 4'(b); s4 = 1'b1;
    @(negedge clk);
    s4 = 1'b0;
    chk("busy4", 32'(bz4), 32'd1);
    n = 1;
    while (!dn4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("lat4", 32'(n), 32'd5);
    chk("diff4", 32'(df4), 32'(ed));
    chk("borrow4", 32'(bo4), (a < b) ? 32'd1 : 32'd0);
    chk("zero4", 32'(z4), (ed == 0) ? 32'd1 : 32'd0);
    @(negedge clk);
    chk("ready_after4", 32'(r4), 32'd1);
    chk("done_clear4", 32'(dn4), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dsum;
    int t, last_t, ops, ea, eb, ed;
    logic [7:0] ca, cb;

    repeat (2) @(negedge clk);
    chk("rst_ready4", 32'(r4), 32'd1);
    chk("rst_busy4", 32'(bz4), 32'd0);
    chk("rst_done4", 32'(dn4), 32'd0);
    chk("rst_diff4", 32'(df4), 32'd0);
    chk("rst_borrow4", 32'(bo4), 32'd0);
    chk("rst_zero4", 32'(z4), 32'd0);
    chk("rst_ready8", 32'(r8), 32'd1);
    chk("rst_diff8", 32'(df8), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    op4(9, 4);
    chk("t1_diff", 32'(df4), 32'h5);
    op4(15, 14);
    chk("t2a_diff", 32'(df4), 32'h1);
    op4(7, 15);
    chk("t2b_diff", 32'(df4), 32'h8);
    chk("t2b_borrow", 32'(bo4), 32'd1);
    op4(5, 5);
    chk("t3a_zero", 32'(z4), 32'd1);
    op4(0, 1);
    chk("t3b_diff", 32'(df4), 32'hF);

    // start re-pulsed mid-RUN must be ignored
    a4 = 4'd9; b4 = 4'd4; s4 = 1'b1;
    @(negedge clk); s4 = 1'b0;
    @(negedge clk); a4 = 4'd0; b4 = 4'd1; s4 = 1'b1;
    @(negedge clk); s4 = 1'b0;
    t = 0;
    while (!dn4 && t < 20) begin @(negedge clk); t++; end
    chk("t4_done_seen", 32'(dn4), 32'd1);
    chk("t4_diff", 32'(df4), 32'h5);
    @(negedge clk);
    @(negedge clk);
    chk("t4_no_queue", 32'(r4), 32'd1);

    // abort on the 2nd RUN cycle
    a4 = 4'd2; b4 = 4'd7; s4 = 1'b1;
    @(negedge clk); s4 = 1'b0;
    @(negedge clk); ab4 = 1'b1;
    @(negedge clk); ab4 = 1'b0;
    chk("abort_ready", 32'(r4), 32'd1);
    chk("abort_busy", 32'(bz4), 32'd0);
    dsum = 0;
    repeat (6) begin @(negedge clk); dsum += int'(dn4); end
    chk("abort_no_done", 32'(dsum), 32'd0);
    chk("abort_diff_kept", 32'(df4), 32'h5);

    // abort coinciding with the final bit
    a4 = 4'd1; b4 = 4'd2; s4 = 1'b1;
    @(negedge clk); s4 = 1'b0;
    repeat (3) @(negedge clk);
    ab4 = 1'b1;
    @(negedge clk); ab4 = 1'b0;
    chk("abort_last_done", 32'(dn4), 32'd0);
    chk("abort_last_ready", 32'(r4), 32'd1);
    chk("abort_last_diff", 32'(df4), 32'h5);
    chk("abort_last_borrow", 32'(bo4), 32'd0);

    // abort in IDLE does nothing
    ab4 = 1'b1;
    @(negedge clk); ab4 = 1'b0;
    chk("abort_idle_ready", 32'(r4), 32'd1);
    op4(12, 3);

    // asynchronous reset mid-RUN
    a4 = 4'd6; b4 = 4'd1; s4 = 1'b1;
    @(negedge clk); s4 = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(r4), 32'd1);
    chk("mid_rst_busy", 32'(bz4), 32'd0);
    chk("mid_rst_done", 32'(dn4), 32'd0);
    chk("mid_rst_diff", 32'(df4), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    op4(3, 1);
    chk("t5_diff", 32'(df4), 32'h2);

    for (int i = 0; i < 40; i++) op4(int'($urandom_range(15)), int'($urandom_range(15)));

    // WIDTH=8 with start held high; operands swapped in on each done
    ca = 8'd200; cb = 8'd55;
    a8 = ca; b8 = cb; s8 = 1'b1;
    t = 0; last_t = -1; ops = 0;
    while (ops < 1002 && t < 20000) begin
      @(negedge clk);
      t++;
      if (dn8) begin
        ea = int'(ca); eb = int'(cb);
        ed = (ea - eb + 256) % 256;
        chk("diff8", 32'(df8), 32'(ed));
        chk("borrow8", 32'(bo8), (ea < eb) ? 32'd1 : 32'd0);
        chk("zero8", 32'(z8), (ed == 0) ? 32'd1 : 32'd0);
        if (ops == 0) chk("t6a_diff", 32'(df8), 32'd145);
        if (ops == 1) begin
          chk("t6b_diff", 32'(df8), 32'd111);
          chk("t6b_borrow", 32'(bo8), 32'd1);
        end
        if (last_t >= 0) chk("gap8", 32'(t - last_t), 32'd10);
        last_t = t;
        ops++;
        if (ops == 1) begin
          ca = 8'd55; cb = 8'd200;
        end else begin
          ca = 8'($urandom); cb = 8'($urandom);
        end
        a8 = ca; b8 = cb;
      end
    end
    s8 = 1'b0;
    chk("ops8", 32'(ops), 32'd1002);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
